// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer: starts the shared mult or div unit, counts its latency and
// commits the result to Hi/Lo with a one-cycle load strobe. All outputs are registered.
module muldiv_seq #(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_mult,
    input  logic             op_div,
    input  logic             b_zero,
    input  logic             abort,
    output logic             mult_start,
    output logic             div_start,
    output logic             sel_mux_hi,
    output logic             sel_mux_lo,
    output logic             HiLo_load,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StWb, StExc} state_e;

    localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    // Select value in force before the current operation, restored if it is aborted.
    logic             sel_save_q, sel_save_d;
    logic             mult_start_q, mult_start_d;
    logic             div_start_q, div_start_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             div_zero_q, div_zero_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        sel_save_d = sel_save_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (op_mult) begin
                    state_d    = StMul;
                    cnt_d      = MulLoad;
                    sel_d      = 1'b1;
                    sel_save_d = sel_q;
                end else if (op_div && !b_zero) begin
                    state_d    = StDiv;
                    cnt_d      = DivLoad;
                    sel_d      = 1'b0;
                    sel_save_d = sel_q;
                end else if (op_div) begin
                    state_d = StExc;
                end
            end
            StMul, StDiv: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    sel_d   = sel_save_q;
                end else if (cnt_q == '0) begin
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StWb:    state_d = StIdle;
            StExc:   state_d = StIdle;
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        mult_start_d = (state_q == StIdle) && (state_d == StMul);
        div_start_d  = (state_q == StIdle) && (state_d == StDiv);
        load_d       = (state_d == StWb);
        busy_d       = (state_d != StIdle);
        div_zero_d   = (state_d == StExc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sel_q        <= 1'b0;
            sel_save_q   <= 1'b0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            sel_save_q   <= sel_save_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            div_zero_q   <= div_zero_d;
        end
    end

    assign mult_start  = mult_start_q;
    assign div_start   = div_start_q;
    assign sel_mux_hi  = sel_q;
    assign sel_mux_lo  = sel_q;
    assign HiLo_load   = load_q;
    assign busy        = busy_q;
    assign done        = load_q;
    assign div_zero    = div_zero_q;
    assign cycle_count = cnt_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer that schedules the shared multiply and divide units of the multicycle CPU datapath. It accepts a multiply or divide request from the main control unit, starts the selected unit, counts its fixed latency and drives the Hi/Lo select muxes and the `HiLo_load` strobe. It also reports divide-by-zero without touching Hi/Lo, and holds `busy` so the main controller stalls until the result is committed.

## Interface
- `MULT_CYCLES`, 32: cycles the mult unit needs after its start pulse (≥1).
- `DIV_CYCLES`, 32: cycles the div unit needs after its start pulse (≥1).
- `CNT_W`, 6: counter width; must hold max(MULT_CYCLES, DIV_CYCLES)−1.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_mult`  in  1  multiply request; level, sampled only in IDLE.
- `op_div`  in  1  divide request; level, sampled only in IDLE.
- `b_zero`  in  1  divisor (B register) equals zero; sampled together with `op_div`.
- `abort`  in  1  synchronous cancel of a running operation.
- `mult_start`  out  1  one-cycle start pulse to the mult unit.
- `div_start`  out  1  one-cycle start pulse to the div unit.
- `sel_mux_hi`  out  1  Hi select: 0 = div result, 1 = mult result.
- `sel_mux_lo`  out  1  Lo select: same encoding as `sel_mux_hi`.
- `HiLo_load`  out  1  one-cycle write enable for Hi and Lo.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, coincident with `HiLo_load`.
- `div_zero`  out  1  one-cycle pulse on a divide with `b_zero`=1.
- `cycle_count`  out  CNT_W  remaining-cycle counter; 0 outside MUL/DIV.

## Operation
- All outputs are registered and decoded from state (Moore).
- States: IDLE, MUL, DIV, WB, EXC.
- IDLE:
  - `op_mult`=1 → MUL, with counter ← MULT_CYCLES−1.
  - Else `op_div`=1 and `b_zero`=0 → DIV, with counter ← DIV_CYCLES−1.
  - Else `op_div`=1 and `b_zero`=1 → EXC.
  - Otherwise stay in IDLE.
- Simultaneous `op_mult` and `op_div`: multiply wins; the divide is dropped, not queued.
- MUL/DIV:
  - Counter decrements each cycle.
  - `abort`=1 → IDLE; no `HiLo_load`, select muxes unchanged from the previous value.
  - Else counter==0 → WB.
- First cycle of MUL: `mult_start`=1. First cycle of DIV: `div_start`=1. Start outputs are 0 in all other cycles.
- Select muxes:
  - On entry to MUL, both `sel_mux_hi` and `sel_mux_lo` ← 1.
  - On entry to DIV, both ← 0.
  - Held through WB and afterwards, until the next MUL/DIV entry.
- WB: `HiLo_load`=1, `done`=1; unconditionally → IDLE. `abort` in WB is ignored.
- EXC: `div_zero`=1 for one cycle; → IDLE. No start pulse, no `HiLo_load`, selects unchanged.
- Requests while `busy`=1 are ignored.
- `cycle_count` mirrors the counter in MUL/DIV and is 0 in IDLE, WB and EXC.

## Timing
- Reset (`reset`=0, asynchronous):
  - State IDLE, counter 0.
  - All 1-bit outputs 0; `sel_mux_hi`=`sel_mux_lo`=0; `cycle_count`=0.
  - Reset asserted mid-operation aborts immediately, with no `HiLo_load`.
  - Reset release is sampled at the next rising edge.
- Request sampled at edge E0:
  - Cycles 1..N (N = MULT_CYCLES or DIV_CYCLES): MUL/DIV. Start pulse in cycle 1; `cycle_count` runs N−1 down to 0.
  - Cycle N+1: WB (`HiLo_load`, `done`).
  - Cycle N+2: IDLE; a new request can be sampled at the end of this cycle.
- `busy` is high for N+1 cycles on the normal path and 1 cycle for EXC.
- Abort asserted in MUL/DIV cycle k: IDLE from cycle k+1.

## Test plan
- Reset: drive `reset`=0 with random inputs → all outputs 0, `cycle_count`=0; release with no requests → outputs stay 0.
- Multiply, default parameters: `op_mult` for one edge → `mult_start` in cycle 1, `cycle_count` 31→0 over cycles 1–32, `HiLo_load`=`done`=1 and selects=1 in cycle 33, `busy` low from cycle 34.
- Divide then divide-by-zero with `DIV_CYCLES`=4:
  - Divide → `div_start` in cycle 1, `HiLo_load` in cycle 5, selects=0.
  - Then `op_div` with `b_zero`=1 → `div_zero` for one cycle; no `div_start`, no `HiLo_load`; selects stay 0.
- Simultaneous `op_mult`+`op_div` → only `mult_start`; selects=1; no `div_start` for the whole operation, including while requests stay held during `busy`.
- Abort: `abort` in MUL cycle 10 → IDLE next cycle, `HiLo_load` never asserted, selects keep their prior value (0 after a preceding divide).
- Async reset mid-DIV: drop `reset` between edges in cycle 3 → outputs 0 immediately, no WB after release; back-to-back multiplies with `MULT_CYCLES`=1 → WB every third cycle.
